// File: rtl/half_adder_pkg.sv
// Shared types and the single-lane half-adder function for the half_adder slice.
package half_adder_pkg;

    localparam int HA_DEFAULT_WIDTH = 1;

    typedef struct packed {
        logic sum;
        logic carry;
    } ha_result_t;

    function automatic ha_result_t ha_eval(input logic a, input logic b);
        ha_result_t r;
        r.sum   = a ^ b;
        r.carry = a & b;
        return r;
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// One-bit combinational half-adder cell: sum = a ^ b, carry = a & b.
module half_adder_cell
    import half_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    ha_result_t res;

    // NOTE: every path through always_comb assigns res, so no latch is inferred.
    always_comb begin
        res = ha_eval(a, b);
    end

    assign sum   = res.sum;
    assign carry = res.carry;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with an optional registered output stage.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH   = HA_DEFAULT_WIDTH,
    parameter bit OUT_REG = 1'b1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    logic [WIDTH-1:0] lane_sum;
    logic [WIDTH-1:0] lane_carry;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (lane_sum[i]),
            .carry (lane_carry[i])
        );
    end

    if (OUT_REG) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic [WIDTH-1:0] carry_q;
        logic             valid_q;

        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        // Data only loads on in_valid, so idle cycles (even with X on a/b) leave it untouched.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    sum_q   <= lane_sum;
                    carry_q <= lane_carry;
                end
            end
        end

        assign sum       = sum_q;
        assign carry     = carry_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        // Clock and reset have no role in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign sum       = lane_sum;
        assign carry     = lane_carry;
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench: registered WIDTH=1 and WIDTH=8 instances plus a combinational WIDTH=1 instance.
module tb_half_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cv, ca, cb;

    logic       ov1, s1, c1;
    logic       ov8;
    logic [7:0] s8, c8;
    logic       ovc, sc, cc;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    half_adder u_reg1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a8[0]), .b(b8[0]), .out_valid(ov1), .sum(s1), .carry(c1)
    );

    half_adder #(.WIDTH(8), .OUT_REG(1'b1)) u_reg8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a8), .b(b8), .out_valid(ov8), .sum(s8), .carry(c8)
    );

    half_adder #(.WIDTH(1), .OUT_REG(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .in_valid(cv),
        .a(ca), .b(cb), .out_valid(ovc), .sum(sc), .carry(cc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lane arithmetic: adding two one-bit numbers gives a two-bit result {carry, sum}.
    function automatic void lane_add(input logic [7:0] x, input logic [7:0] y,
                                     output logic [7:0] s, output logic [7:0] c);
        for (int i = 0; i < 8; i++) begin
            int t;
            t    = int'(x[i]) + int'(y[i]);
            s[i] = (t % 2) == 1;
            c[i] = (t / 2) == 1;
        end
    endfunction

    // Model of the registered build: last accepted result plus a one-cycle valid.
    logic       m_valid = 1'b0;
    logic [7:0] m_sum   = '0;
    logic [7:0] m_carry = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_sum   = '0;
            m_carry = '0;
        end else begin
            m_valid = in_valid;
            if (in_valid) lane_add(a8, b8, m_sum, m_carry);
        end
    end

    // Compare process: every falling edge, all three instances against the model.
    always @(negedge clk) begin
        logic [7:0] es, ec;
        check("reg8_valid", ov8, m_valid);
        check("reg8_sum",   s8,  m_sum);
        check("reg8_carry", c8,  m_carry);
        check("reg1_valid", ov1, m_valid);
        check("reg1_sum",   s1,  m_sum[0]);
        check("reg1_carry", c1,  m_carry[0]);
        lane_add({7'b0, ca}, {7'b0, cb}, es, ec);
        check("comb_valid", ovc, cv);
        check("comb_sum",   sc,  es[0]);
        check("comb_carry", cc,  ec[0]);
    end

    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y);
        in_valid = v;
        a8       = x;
        b8       = y;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] tt_a, tt_b, tt_s, tt_c;
        rst_n = 1'b0; in_valid = 1'b0; a8 = '0; b8 = '0;
        cv = 1'b0; ca = 1'b0; cb = 1'b0;
        #1;
        check("rst_sum",   s8,  8'h00);
        check("rst_carry", c8,  8'h00);
        check("rst_valid", ov8, 1'b0);

        // Combinational instance stepped through the truth table while rst_n is low.
        tt_a = 4'b1100; tt_b = 4'b1010; tt_s = 4'b0110; tt_c = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            ca = tt_a[i]; cb = tt_b[i]; cv = i[0];
            #1;
            check("comb_tt_sum",   sc,  tt_s[i]);
            check("comb_tt_carry", cc,  tt_c[i]);
            check("comb_tt_valid", ovc, i[0]);
        end
        #4 rst_n = 1'b1;
        ca = 1'b1; cb = 1'b1; cv = 1'b1;
        #1;
        check("comb_rst_hi_sum",   sc, 1'b0);
        check("comb_rst_hi_carry", cc, 1'b1);
        rst_n = 1'b0;
        #1;
        check("comb_rst_lo_carry", cc,  1'b1);
        check("comb_rst_lo_valid", ovc, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Truth table on consecutive cycles, registered WIDTH=1.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, {7'b0, tt_a[i]}, {7'b0, tt_b[i]});
            check("tt_sum",   s1,  tt_s[i]);
            check("tt_carry", c1,  tt_c[i]);
            check("tt_valid", ov1, 1'b1);
        end

        // Hold: idle cycles with different inputs must not disturb the last result.
        drive(1'b1, 8'h01, 8'h01);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 8'h01);
            check("hold_sum",   s1,  1'b0);
            check("hold_carry", c1,  1'b1);
            check("hold_valid", ov1, 1'b0);
        end

        // Independent lanes: no carry crosses between bits.
        drive(1'b1, 8'h0C, 8'h0A);
        check("lanes4_sum",   s8, 8'h06);
        check("lanes4_carry", c8, 8'h08);
        drive(1'b1, 8'hCC, 8'hAA);
        check("lanes8_sum",   s8, 8'h66);
        check("lanes8_carry", c8, 8'h88);
        check("lanes8_valid", ov8, 1'b1);

        // Asynchronous reset between edges clears outputs immediately.
        in_valid = 1'b1; a8 = 8'hFF; b8 = 8'h0F;
        #2 rst_n = 1'b0;
        #1;
        check("async_sum",   s8,  8'h00);
        check("async_carry", c8,  8'h00);
        check("async_valid", ov8, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'hFF, 8'hFF);
            check("inrst_carry", c8,  8'h00);
            check("inrst_valid", ov8, 1'b0);
        end
        #3 rst_n = 1'b1;
        #1;
        drive(1'b1, 8'h01, 8'h00);
        check("post_rst_sum",   s1,  1'b1);
        check("post_rst_carry", c1,  1'b0);
        check("post_rst_valid", ov1, 1'b1);

        // Random traffic; the compare process checks every cycle.
        for (int i = 0; i < 1000; i++) begin
            cv = 1'($urandom_range(0, 1));
            ca = 1'($urandom_range(0, 1));
            cb = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end
        drive(1'b0, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
